imem_boot_loader: RTL

- Byte-serial boot loader sitting directly upstream of `MIPS_Processor`.
- Receives a framed program image over a valid/ready byte stream and writes it word-by-word into instruction memory.
- Holds the processor in reset during the load, then releases it once the frame's checksum verifies.
- Single clock domain; sits between the host-side byte source (UART RX or bench driver) and the instruction-memory write port.

---
 rtl/imem_boot_loader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Byte-serial boot loader for the instruction memory of MIPS_Processor.
// A framed program image arrives on a valid/ready byte stream:
//   HEADER, N (word count), 4*N data bytes (little-endian per word), XOR checksum.
// Each assembled word is written into instruction memory. The processor is
// held in reset until the checksum of a complete frame verifies.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   rx_data     incoming byte
//   rx_valid    rx_data valid this cycle
//   rx_ready    loader accepts a byte this cycle (low only in the write cycle)
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address for the write
//   imem_wdata  word to write
//   cpu_reset   active-high reset to the processor
//   load_done   image loaded and verified, processor running
//   load_error  last frame rejected (bad count or checksum)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    // Control state
    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   widx_q, widx_d;     // one extra bit so N = 2**ADDR_W fits
    logic [1:0]        bidx_q, bidx_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;

    // Datapath state (no reset needed; always initialised in COUNT before use)
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;

    logic              accept;
    logic              count_bad;
    logic [ADDR_W:0]   widx_inc;
    logic [31:0]       word_shift;

    assign accept     = rx_valid && rx_ready_q;
    // Count is checked at 32 bits so any ADDR_W (smaller or larger than 8) works.
    assign count_bad  = (rx_data == 8'h00) || ({24'd0, rx_data} > (32'd1 << ADDR_W));
    assign widx_inc   = widx_q + (ADDR_W+1)'(1);
    // Bytes shift in from the top, so the first byte ends up in bits 7:0.
    assign word_shift = {rx_data, word_q[31:8]};

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        bidx_d       = bidx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        count_d      = count_q;
        word_d       = word_q;
        csum_d       = csum_q;

        case (state_q)
            S_IDLE: begin
                if (accept && (rx_data == HEADER)) begin
                    state_d     = S_COUNT;
                    cpu_reset_d = 1'b1;
                    load_done_d = 1'b0;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    if (count_bad) begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        // Range already checked, so the narrowing cast is lossless.
                        count_d = (ADDR_W+1)'(rx_data);
                        widx_d  = '0;
                        bidx_d  = 2'd0;
                        csum_d  = 8'h00;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = word_shift;
                    csum_d = csum_q ^ rx_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d      = S_WRITE;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = widx_q[ADDR_W-1:0];
                        imem_wdata_d = word_shift;
                    end
                end
            end
            S_WRITE: begin
                widx_d  = widx_inc;
                state_d = (widx_inc == count_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d     = S_RUN;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept && (rx_data == HEADER)) begin
                    state_d     = S_COUNT;
                    cpu_reset_d = 1'b1;
                    load_done_d = 1'b0;
                end
            end
            S_ERROR: begin
                if (accept && (rx_data == HEADER)) begin
                    state_d      = S_COUNT;
                    load_error_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered ready: drops exactly for the cycle spent in WRITE.
        rx_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            widx_q       <= '0;
            bidx_q       <= 2'd0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        word_q  <= word_d;
        csum_q  <= csum_d;
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule
